// File: rtl/tb_exit_status_slave.sv
// tb_exit_status_slave
//   Memory-mapped responder used by firmware inside the simulation wrapper to
//   report pass/fail, an exit code, and console characters.
//
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     req_i/gnt_o            request (pre-decoded) and combinational grant
//     addr_i, we_i, be_i,    byte offset (bits [3:2] decoded), write enable,
//     wdata_i                byte enables, write data
//     rvalid_o, rdata_o      one-cycle response pulse and registered read data
//     char_valid_o/ready_i,  stdout byte stream drained from the FIFO head
//     char_data_o
//     tests_passed_o,        sticky termination flags and latched exit code
//     tests_failed_o,
//     exit_valid_o,
//     exit_value_o
//
//   Register map (addr_i[3:2]):
//     0 STDOUT  W: push wdata_i[7:0]     R: FIFO fill count
//     1 STATUS  W: PASS/FAIL magic       R: {30'b0, failed, passed}
//     2 EXIT    W: latch exit code       R: exit code
//     3 CYCLE   W: ignored               R: free-running cycle counter
module tb_exit_status_slave #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] PASS_MAGIC = 32'd123456789,
   parameter logic [31:0] FAIL_MAGIC = 32'd1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [3:0]  addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        char_valid_o,
   input  logic        char_ready_i,
   output logic [7:0]  char_data_o,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      REG_STDOUT = 2'd0,
      REG_STATUS = 2'd1,
      REG_EXIT   = 2'd2,
      REG_CYCLE  = 2'd3
   } reg_e;

   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]   mem_q [FIFO_DEPTH];
   logic [7:0]   mem_d [FIFO_DEPTH];
   logic         passed_q, passed_d, failed_q, failed_d;
   logic         exit_valid_q, exit_valid_d;
   logic [31:0]  exit_value_q, exit_value_d;
   logic [31:0]  cycle_q, cycle_d;
   logic         rvalid_q, rvalid_d;
   logic [31:0]  rdata_q, rdata_d;

   reg_e         sel;
   logic         fifo_empty, fifo_full;
   logic [AW:0]  fill_cnt;
   logic         xfer, push, pop, done;
   logic         unused_addr_lsbs;

   assign unused_addr_lsbs = ^addr_i[1:0];

   assign sel        = reg_e'(addr_i[3:2]);
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fill_cnt   = wr_ptr_q - rd_ptr_q;

   // Full is the registered state, so a pop in the stalled cycle only frees
   // the slot for the following cycle.
   assign gnt_o = req_i && !(we_i && (sel == REG_STDOUT) && fifo_full);
   assign xfer  = req_i && gnt_o;
   assign push  = xfer && we_i && (sel == REG_STDOUT) && be_i[0];
   assign pop   = char_valid_o && char_ready_i;
   assign done  = passed_q || failed_q || exit_valid_q;

   assign char_valid_o   = !fifo_empty;
   assign char_data_o    = mem_q[rd_ptr_q[AW-1:0]];
   assign rvalid_o       = rvalid_q;
   assign rdata_o        = rdata_q;
   assign tests_passed_o = passed_q;
   assign tests_failed_o = failed_q;
   assign exit_valid_o   = exit_valid_q;
   assign exit_value_o   = exit_value_q;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_d        = mem_q;
      passed_d     = passed_q;
      failed_d     = failed_q;
      exit_valid_d = exit_valid_q;
      exit_value_d = exit_value_q;
      cycle_d      = cycle_q + 32'd1;
      rvalid_d     = xfer;
      rdata_d      = '0;

      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata_i[7:0];
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      if (xfer) begin
         if (we_i) begin
            // First terminal event wins: once done, STATUS/EXIT are frozen.
            if ((be_i == 4'hF) && !done) begin
               case (sel)
                  REG_STATUS: begin
                     if (wdata_i == PASS_MAGIC)      passed_d = 1'b1;
                     else if (wdata_i == FAIL_MAGIC) failed_d = 1'b1;
                  end
                  REG_EXIT: begin
                     exit_valid_d = 1'b1;
                     exit_value_d = wdata_i;
                  end
                  default: ;
               endcase
            end
         end else begin
            case (sel)
               REG_STDOUT: rdata_d = 32'(fill_cnt);
               REG_STATUS: rdata_d = {30'b0, failed_q, passed_q};
               REG_EXIT:   rdata_d = exit_value_q;
               default:    rdata_d = cycle_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_q        <= '{default: '0};
         passed_q     <= 1'b0;
         failed_q     <= 1'b0;
         exit_valid_q <= 1'b0;
         exit_value_q <= '0;
         cycle_q      <= '0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_q        <= mem_d;
         passed_q     <= passed_d;
         failed_q     <= failed_d;
         exit_valid_q <= exit_valid_d;
         exit_value_q <= exit_value_d;
         cycle_q      <= cycle_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
      end
   end

endmodule
